// File: rtl/audio_pll_lock_sequencer.sv
// Reset/lock sequencer for the 12.288 MHz audio PLL: pulses PLL reset, waits for lock with
// timeout and retries, qualifies lock stability, then releases the audio reset. Optional
// lock-loss counter is built when AUDIO_PLL_LOSS_COUNT_EN is defined.
module audio_pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          restart,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic          audio_reset_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_count
`ifdef AUDIO_PLL_LOSS_COUNT_EN
  ,
  output logic [7:0]    loss_count
`endif
);

  localparam int CMAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CMAX   = (CMAX_A > RST_CYCLES) ? CMAX_A : RST_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R       = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_OFF, S_ASSERT_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   retry_n;
  logic            lock_m, lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // One shared counter serves the reset pulse, lock timeout and stability window; every
  // phase compares against its own last value, so the count never passes CMAX-1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_count;
    if (!enable) begin
      state_n = S_OFF;
      cnt_n   = '0;
      retry_n = '0;
    end else if (restart) begin
      state_n = S_ASSERT_RST;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_ASSERT_RST;
          cnt_n   = '0;
          retry_n = '0;
        end
        S_ASSERT_RST: begin
          if (cnt == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_n = '0;
            if (retry_count < MAX_R) begin
              state_n = S_ASSERT_RST;
              retry_n = retry_count + 1'b1;
            end else begin
              state_n = S_FAULT;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_n = S_ASSERT_RST;
            cnt_n   = '0;
            retry_n = '0;
          end
        end
        S_FAULT: ;
        default: state_n = S_OFF;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_OFF;
      cnt           <= '0;
      retry_count   <= '0;
      pll_rst       <= 1'b1;
      audio_reset_n <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry_count   <= retry_n;
      pll_rst       <= (state_n == S_OFF) || (state_n == S_ASSERT_RST) || (state_n == S_FAULT);
      audio_reset_n <= (state_n == S_RUN);
      ready         <= (state_n == S_RUN);
      fault         <= (state_n == S_FAULT);
    end
  end

`ifdef AUDIO_PLL_LOSS_COUNT_EN
  logic lost;
  assign lost = enable && !restart && (state == S_RUN) && !lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= '0;
    end else if (lost && (loss_count != 8'hFF)) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// Self-checking bench for audio_pll_lock_sequencer: directed scenarios plus randomized PLL
// behaviour, compared every cycle against an elapsed-time reference model.
module tb_audio_pll_lock_sequencer;
  localparam int RST = 4;
  localparam int LT  = 100;
  localparam int SC  = 8;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, audio_reset_n, ready, fault;
  logic [1:0] retry_count;
`ifdef AUDIO_PLL_LOSS_COUNT_EN
  logic [7:0] loss_count;
`endif

  audio_pll_lock_sequencer #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .pll_locked(pll_locked), .pll_rst(pll_rst), .audio_reset_n(audio_reset_n),
    .ready(ready), .fault(fault), .retry_count(retry_count)
`ifdef AUDIO_PLL_LOSS_COUNT_EN
    , .loss_count(loss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase name plus the edge at which the phase was entered.
  string ph;
  int    cyc, since, retries, loss;
  bit    lq[$];

  function automatic void m_reset();
    ph = "OFF"; since = cyc; retries = 0; loss = 0;
    lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
  endfunction

  function automatic void go(input string p);
    ph = p; since = cyc;
  endfunction

  function automatic void m_step();
    bit ls;
    cyc++;
    ls = lq.pop_front();           // lock as seen two edges after it was sampled
    lq.push_back(pll_locked);
    if (!enable) begin
      if (ph != "OFF") go("OFF");
      retries = 0;
    end else if (restart) begin
      go("ARST"); retries = 0;
    end else if (ph == "OFF") begin
      go("ARST"); retries = 0;
    end else if (ph == "ARST") begin
      if (cyc - since == RST) go("WAIT");
    end else if (ph == "WAIT") begin
      if (ls) go("STABLE");
      else if (cyc - since == LT) begin
        if (retries < MR) begin retries++; go("ARST"); end
        else go("FAULT");
      end
    end else if (ph == "STABLE") begin
      if (!ls) go("WAIT");
      else if (cyc - since == SC) go("RUN");
    end else if (ph == "RUN") begin
      if (!ls) begin go("ARST"); retries = 0; if (loss < 255) loss++; end
    end
  endfunction

  task automatic m_check();
    bit run = (ph == "RUN");
    check("pll_rst", pll_rst, (ph == "OFF" || ph == "ARST" || ph == "FAULT"));
    check("audio_reset_n", audio_reset_n, run);
    check("ready", ready, run);
    check("fault", fault, ph == "FAULT");
    check("retry_count", retry_count, retries);
    check("inv_no_release_in_rst", audio_reset_n & pll_rst, 0);
    check("inv_retry_max", retry_count <= 2'd2, 1);
`ifdef AUDIO_PLL_LOSS_COUNT_EN
    check("loss_count", loss_count, loss);
`endif
  endtask

  // Behavioural PLL: locks lock_delay cycles after its reset falls, optional forced drops.
  int low_cnt = 0, lock_delay = 10, drop_left = 0;
  bit never = 0, rnd_mode = 0;

  task automatic env_update();
    if (pll_rst) begin
      low_cnt = 0;
      if (rnd_mode) begin
        lock_delay = $urandom_range(0, 120);
        never = ($urandom_range(0, 7) == 0);
      end
    end else low_cnt++;
    pll_locked = !never && !pll_rst && (low_cnt >= lock_delay) && (drop_left == 0);
    if (drop_left > 0) drop_left--;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) m_step();
    @(negedge clk);
    m_check();
    env_update();
  endtask

  task automatic run_until(input string p, input int budget, output int rises, output int falls);
    logic prev;
    int n = 0;
    rises = 0; falls = 0;
    while (ph != p && n < budget) begin
      prev = pll_rst;
      tick();
      if (!prev && pll_rst) rises++;
      if (prev && !pll_rst) falls++;
      n++;
    end
    if (ph != p) check({"timeout_", p}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r, f, lat;
    cyc = 0;
    m_reset();
    @(negedge clk);
    m_check();
    tick(); tick();
    reset_n = 1'b1;

    // Bring-up
    enable = 1'b1; never = 0; lock_delay = 10;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst) n++; else break;
    end
    check("t1_rst_len", n, RST);
    run_until("STABLE", 200, r, f);
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    check("t1_stable_len", n, SC);
    check("t1_retry", retry_count, 0);

    // Never locks: lock loss from RUN then two retries, then FAULT
    never = 1;
    run_until("FAULT", 600, r, f);
    check("t2_pulses", f, 3);
    check("t2_fault", fault, 1);
    for (int i = 0; i < 20; i++) tick();
    check("t2_rst_held", pll_rst, 1);
    never = 0;
    restart = 1'b1; tick(); restart = 1'b0;
    check("t2_fault_clr", fault, 0);
    check("t2_retry_clr", retry_count, 0);
    run_until("RUN", 300, r, f);
    check("t2_new_pulse", f, 1);

    // Glitch during the stability window
    restart = 1'b1; tick(); restart = 1'b0;
    run_until("STABLE", 200, r, f);
    for (int i = 0; i < 5; i++) tick();
    drop_left = 1;
    run_until("RUN", 300, r, f);
    check("t3_no_pulse", r, 0);

    // Lock loss in RUN
    drop_left = 3;
    lat = 0;
    while (ready && lat < 10) begin tick(); lat++; end
    check("t4_drop_latency", (lat <= 3), 1);
    run_until("RUN", 300, r, f);
    check("t4_recovered", ready, 1);

    // enable=0 beats restart while waiting for lock
    never = 1;
    restart = 1'b1; tick(); restart = 1'b0;
    run_until("WAIT", 50, r, f);
    enable = 1'b0; restart = 1'b1; tick(); restart = 1'b0;
    check("t5_pll_rst", pll_rst, 1);
    tick();
    never = 0; enable = 1'b1;
    run_until("STABLE", 300, r, f);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1 m_reset();
    m_check();
    tick(); tick();
    reset_n = 1'b1;

    // Randomized operation
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 79) == 0) drop_left = $urandom_range(1, 3);
      tick();
    end
    restart = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
